// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared types and defaults for the TCM request arbiter
package tcm_pkg;

   typedef enum logic [1:0] {
      RSP_IDLE  = 2'd0,
      RSP_IF    = 2'd1,
      RSP_LS_RD = 2'd2,
      RSP_LS_WR = 2'd3
   } rsp_state_e;

   localparam int STARVE_LIMIT_DEF = 4;
   localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/tcm_req_arbiter.sv
// rtl/tcm_req_arbiter.sv - two-port (fetch, load/store) arbiter onto one TCM request port
module tcm_req_arbiter
   import tcm_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic              ls_we,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_wr,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_data_rd
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    starve_hit;
   rsp_state_e              state;
   rsp_state_e              state_nxt;

   // LS normally wins; a fetch denied LIMIT cycles in a row takes the port once.
   assign starve_hit = if_req && (starve_cnt == LIMIT);
   assign if_gnt     = !rst && if_req && (!ls_req || starve_hit);
   assign ls_gnt     = !rst && ls_req && !if_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (if_req && !if_gnt) begin
         if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   always_comb begin
      mem_addr    = '0;
      mem_data_wr = '0;
      mem_we      = 1'b0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_addr    = ls_addr;
         mem_data_wr = ls_wdata;
         mem_we      = ls_we;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RSP_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = RSP_IDLE;
      if (if_gnt) begin
         state_nxt = RSP_IF;
      end else if (ls_gnt) begin
         state_nxt = ls_we ? RSP_LS_WR : RSP_LS_RD;
      end
   end

   // Response lands the cycle after the grant; store acks carry no data.
   always_comb begin
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      if (!rst) begin
         case (state)
            RSP_IF: begin
               if_rvalid = 1'b1;
               if_rdata  = mem_data_rd;
            end
            RSP_LS_RD: begin
               ls_rvalid = 1'b1;
               ls_rdata  = mem_data_rd;
            end
            RSP_LS_WR: begin
               ls_rvalid = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tcm_req_arbiter.sv
// tb/tb_tcm_req_arbiter.sv - directed self-checking bench for tcm_req_arbiter
module tb_tcm_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic [31:0] ls_addr;
   logic        ls_we;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_wr;
   logic        mem_we;
   logic [31:0] mem_data_rd;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tcm_req_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt),
      .if_rvalid   (if_rvalid),
      .if_rdata    (if_rdata),
      .ls_req      (ls_req),
      .ls_addr     (ls_addr),
      .ls_we       (ls_we),
      .ls_wdata    (ls_wdata),
      .ls_gnt      (ls_gnt),
      .ls_rvalid   (ls_rvalid),
      .ls_rdata    (ls_rdata),
      .mem_addr    (mem_addr),
      .mem_data_wr (mem_data_wr),
      .mem_we      (mem_we),
      .mem_data_rd (mem_data_rd)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_if;
      rst         = 1'b1;
      if_req      = 1'b1;
      if_addr     = 32'h0000_0040;
      ls_req      = 1'b1;
      ls_addr     = 32'h0000_0080;
      ls_we       = 1'b1;
      ls_wdata    = 32'hFFFF_FFFF;
      mem_data_rd = 32'hCAFE_F00D;
      #2;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_ls_gnt", ls_gnt, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wdata", mem_data_wr, 0);
      tick();
      tick();
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_ls_rvalid", ls_rvalid, 0);
      check("rst_ls_rdata", ls_rdata, 0);
      check("rst_starve", dut.starve_cnt, 0);

      // idle after reset
      if_req = 1'b0;
      ls_req = 1'b0;
      rst    = 1'b0;
      #1;
      check("idle_gnt", {if_gnt, ls_gnt}, 0);
      check("idle_mem_addr", mem_addr, 0);
      tick();
      check("idle_rvalid", {if_rvalid, ls_rvalid}, 0);
      check("idle_starve", dut.starve_cnt, 0);

      // single fetch
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      #1;
      check("if_gnt", if_gnt, 1);
      check("if_ls_gnt", ls_gnt, 0);
      check("if_mem_addr", mem_addr, 32'h100);
      check("if_mem_we", mem_we, 0);
      tick();
      if_req      = 1'b0;
      mem_data_rd = 32'hDEAD_BEEF;
      #1;
      check("if_rvalid", if_rvalid, 1);
      check("if_rdata", if_rdata, 32'hDEAD_BEEF);
      check("if_ls_rvalid", ls_rvalid, 0);

      // simultaneous, LS store wins
      if_req   = 1'b1;
      if_addr  = 32'h0000_0200;
      ls_req   = 1'b1;
      ls_we    = 1'b1;
      ls_addr  = 32'h8000_0010;
      ls_wdata = 32'h1234_5678;
      #1;
      check("st_ls_gnt", ls_gnt, 1);
      check("st_if_gnt", if_gnt, 0);
      check("st_mem_we", mem_we, 1);
      check("st_mem_addr", mem_addr, 32'h8000_0010);
      check("st_mem_wdata", mem_data_wr, 32'h1234_5678);
      tick();
      if_req      = 1'b0;
      ls_req      = 1'b0;
      mem_data_rd = 32'h55AA_55AA;
      #1;
      check("st_rvalid", ls_rvalid, 1);
      check("st_rdata", ls_rdata, 0);
      check("st_if_rvalid", if_rvalid, 0);
      tick();

      // starvation: both held, fetch wins every fifth cycle
      ls_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if_req = 1'b1;
         ls_req = 1'b1;
         #1;
         exp_if = ((i % 5) == 4);
         check($sformatf("starve_if_gnt_%0d", i), if_gnt, exp_if);
         check($sformatf("starve_ls_gnt_%0d", i), ls_gnt, !exp_if);
         tick();
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      #1;
      check("starve_cleared", dut.starve_cnt, 0);
      tick();

      // alternating fetch / load, back to back
      for (int k = 0; k < 6; k++) begin
         if_req      = (k < 5) && (k % 2 == 0);
         ls_req      = (k < 5) && (k % 2 == 1);
         if_addr     = 32'h0000_0200 + k;
         ls_addr     = 32'h0000_0300 + k;
         mem_data_rd = 32'hA000_0000 + k;
         #1;
         if (k < 5) begin
            check($sformatf("alt_if_gnt_%0d", k), if_gnt, (k % 2 == 0));
            check($sformatf("alt_ls_gnt_%0d", k), ls_gnt, (k % 2 == 1));
            check($sformatf("alt_mem_addr_%0d", k), mem_addr,
                  (k % 2 == 0) ? 32'h0000_0200 + k : 32'h0000_0300 + k);
         end
         if (k > 0) begin
            check($sformatf("alt_if_rvalid_%0d", k), if_rvalid, ((k - 1) % 2 == 0));
            check($sformatf("alt_ls_rvalid_%0d", k), ls_rvalid, ((k - 1) % 2 == 1));
            check($sformatf("alt_rdata_%0d", k), ((k - 1) % 2 == 0) ? if_rdata : ls_rdata,
                  32'hA000_0000 + k);
         end
         tick();
      end
      if_req = 1'b0;
      ls_req = 1'b0;

      // reset right after a load grant discards the response
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h0000_0400;
      #1;
      check("rst_ld_gnt", ls_gnt, 1);
      tick();
      ls_req = 1'b0;
      if_req = 1'b1;
      rst    = 1'b1;
      #1;
      check("rstmid_ls_rvalid", ls_rvalid, 0);
      check("rstmid_ls_rdata", ls_rdata, 0);
      check("rstmid_if_gnt", if_gnt, 0);
      check("rstmid_mem_addr", mem_addr, 0);
      tick();
      if_req = 1'b0;
      rst    = 1'b0;
      #1;
      check("post_rst_ls_rvalid", ls_rvalid, 0);
      tick();
      check("post_rst_rvalid", {if_rvalid, ls_rvalid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tcm_req_arbiter.md
TCM_REQ_ARBITER -- requirements
Module: tcm_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all ports.
REQ-002 Parameter: DATA_W, default 32, data width of all ports.
REQ-003 Parameter: STARVE_LIMIT, default 4, number of consecutive denied IF cycles before IF gets priority; legal range 1..15.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous and active-high.
REQ-006 Port: if_req  in  1  instruction-fetch read request.
REQ-007 Port: if_addr  in  ADDR_W  fetch address.
REQ-008 Port: if_gnt  out  1  fetch request accepted this cycle.
REQ-009 Port: if_rvalid  out  1  fetch read data valid.
REQ-010 Port: if_rdata  out  DATA_W  fetch read data.
REQ-011 Port: ls_req  in  1  load/store request.
REQ-012 Port: ls_addr  in  ADDR_W  load/store address.
REQ-013 Port: ls_we  in  1  1 = store, 0 = load.
REQ-014 Port: ls_wdata  in  DATA_W  store data.
REQ-015 Port: ls_gnt  out  1  load/store request accepted this cycle.
REQ-016 Port: ls_rvalid  out  1  load data valid or store acknowledge.
REQ-017 Port: ls_rdata  out  DATA_W  load data.
REQ-018 Port: mem_addr / mem_data_wr / mem_we  out  ADDR_W / DATA_W / 1  unified request to the downstream TCM partition controller.
REQ-019 Port: mem_data_rd  in  DATA_W  unified read data, valid one cycle after the request.

Function
REQ-020 At most one of if_gnt, ls_gnt SHALL be high in any cycle; grants are combinational from the requests and registered state, with zero-cycle acceptance.
REQ-021 Default priority: ls_req wins over if_req.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each cycle with if_req=1 and if_gnt=0, and clear on any cycle with if_gnt=1 or if_req=0.
REQ-023 When starve_cnt == STARVE_LIMIT and if_req=1, IF SHALL be granted over LS in that cycle.
REQ-024 Granted IF: mem_addr=if_addr, mem_we=0, mem_data_wr=0.
REQ-025 Granted LS: mem_addr=ls_addr, mem_we=ls_we, mem_data_wr=ls_wdata.
REQ-026 No grant: mem_addr=0, mem_data_wr=0, mem_we=0.
REQ-027 Response FSM, states RSP_IDLE, RSP_IF, RSP_LS_RD, RSP_LS_WR; next state each cycle = RSP_IF if if_gnt, RSP_LS_RD if ls_gnt and ls_we=0, RSP_LS_WR if ls_gnt and ls_we=1, else RSP_IDLE.
REQ-028 RSP_IF: if_rvalid=1 and if_rdata=mem_data_rd.
REQ-029 RSP_LS_RD: ls_rvalid=1 and ls_rdata=mem_data_rd.
REQ-030 RSP_LS_WR: ls_rvalid=1 and ls_rdata=0.
REQ-031 In every other state the corresponding rvalid SHALL be 0 and its rdata 0.
REQ-032 Latency: grant at cycle N, response at cycle N+1. Back-to-back grants SHALL be sustained at one per cycle, so a new grant may coincide with the previous response.
REQ-033 A request held high after its grant SHALL be treated as a new request; the requester drops req to avoid a duplicate.

Reset
REQ-034 While rst=1: FSM=RSP_IDLE, starve_cnt=0, all gnt=0, all rvalid=0, all rdata=0, mem_addr=0, mem_data_wr=0, mem_we=0, regardless of requests.
REQ-035 Reset asserted mid-transaction SHALL discard the pending response; no rvalid after rst deasserts until a new grant.

Structure
REQ-036 Shared package tcm_pkg SHALL hold the rsp_state_e enum and the STARVE_LIMIT default.
REQ-037 Single module; no sub-module required.

Verification
REQ-038 if_req=1, addr=0x0000_0100, ls_req=0 -> if_gnt same cycle, mem_addr=0x100, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_data_rd (0xDEAD_BEEF).
REQ-039 Both requests together, ls_we=1, ls_addr=0x8000_0010, wdata=0x1234_5678 -> ls_gnt only, mem_we=1; next cycle ls_rvalid=1, ls_rdata=0.
REQ-040 ls_req held high and if_req held high for 10 cycles, STARVE_LIMIT=4 -> ls_gnt cycles 0-3, if_gnt cycle 4, starve_cnt clears, pattern repeats.
REQ-041 Alternating IF/LS grants on consecutive cycles -> one rvalid per cycle to the correct owner with no gaps or swapped data.
REQ-042 rst pulsed the cycle after an LS load grant -> no ls_rvalid; all outputs 0 during reset.
REQ-043 No requests -> mem_addr=0, mem_we=0, no gnt, no rvalid, starve_cnt remains 0.
